ram_seq_ctrl: RTL and testbench

Parametrised sequencer for a single-port synchronous RAM with one-cycle read latency. A write sweep fills every address with a selectable data pattern. A paced read sweep walks every address, checks each returned word against the same pattern and counts mismatches. It sits between key/command logic and the RAM instance, and is the general successor of the fixed 8-bit, 256-deep fill/readback controller.

---
 rtl/ram_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ram_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: write-fill and paced read-check sequencer for a 1-cycle-latency single-port RAM
module ram_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_DIV = 10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_start,
  input  logic              rd_start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] rd_data,
  output logic              w_en,
  output logic              r_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic              err_flag
);
  localparam int CW = $clog2(RD_DIV);
  localparam logic [CW-1:0] CMAX = CW'(RD_DIV - 1);
  localparam logic [ADDR_W-1:0] AMAX = '1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, CHECK} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [DATA_W-1:0] data_q, data_d, exp_q, exp_d, seed_q, seed_d;
  logic [1:0]        mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
  logic              w_en_q, w_en_d, r_en_q, r_en_d, busy_q, busy_d, done_q, done_d;
  logic              err_flag_q, err_flag_d, chk_q, chk_d;

  // The address is widened to the data width before inversion, so mode 1 sets all upper data bits.
  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [DATA_W-1:0] s,
                                            input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ae;
    ae = DATA_W'(a);
    return m == 2'd0 ? ae : m == 2'd1 ? ~ae : m == 2'd2 ? s : s + ae;
  endfunction

  assign addr_inc = addr_q + 1'b1;

  // State and output registers; every output is driven straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      exp_q      <= '0;
      seed_q     <= '0;
      mode_q     <= '0;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      w_en_q     <= 1'b0;
      r_en_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_flag_q <= 1'b0;
      chk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      exp_q      <= exp_d;
      seed_q     <= seed_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      w_en_q     <= w_en_d;
      r_en_q     <= r_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_flag_q <= err_flag_d;
      chk_q      <= chk_d;
    end
  end

  // Next state: strobes, addr and data default to the idle values; a compare is dropped on abort.
  always_comb begin
    state_d    = state_q;
    addr_d     = '0;
    data_d     = '0;
    w_en_d     = 1'b0;
    r_en_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    chk_d      = 1'b0;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (chk_q && !abort && rd_data != exp_q) begin
      err_cnt_d  = err_cnt_q + 1'b1;
      err_flag_d = 1'b1;
    end
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_start) begin
            state_d = WRITE;
            mode_d  = mode;
            seed_d  = seed;
            w_en_d  = 1'b1;
            busy_d  = 1'b1;
            data_d  = pat(mode, seed, '0);
          end else if (rd_start) begin
            state_d    = READ;
            mode_d     = mode;
            seed_d     = seed;
            busy_d     = 1'b1;
            cnt_d      = '0;
            err_cnt_d  = '0;
            err_flag_d = 1'b0;
          end
        end
        WRITE: begin
          if (addr_q == AMAX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            w_en_d = 1'b1;
            busy_d = 1'b1;
            addr_d = addr_inc;
            data_d = pat(mode_q, seed_q, addr_inc);
          end
        end
        READ: begin
          busy_d  = 1'b1;
          cnt_d   = cnt_q == CMAX ? '0 : cnt_q + 1'b1;
          r_en_d  = cnt_q == CMAX;
          addr_d  = r_en_q ? addr_inc : addr_q;
          chk_d   = r_en_q;
          exp_d   = pat(mode_q, seed_q, addr_q);
          state_d = r_en_q && addr_q == AMAX ? CHECK : READ;
        end
        default: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      endcase
    end
  end

  assign w_en     = w_en_q;
  assign r_en     = r_en_q;
  assign addr     = addr_q;
  assign data_in  = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl: directed bench for ram_seq_ctrl with a 16x8 one-cycle-latency RAM
module tb_ram_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_start = 1'b0, rd_start = 1'b0, abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] seed = 8'd0;
  logic [7:0] rd_data;
  logic       w_en, r_en, busy, done, err_flag;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic [4:0] err_cnt;
  logic [7:0] mem [16];
  logic       cor_en = 1'b0;
  logic [3:0] cor_addr = 4'd0;
  logic [7:0] cor_data = 8'd0;
  int         checks = 0, errors = 0;

  ram_seq_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .rd_start(rd_start), .abort(abort),
    .mode(mode), .seed(seed), .rd_data(rd_data), .w_en(w_en), .r_en(r_en), .addr(addr),
    .data_in(data_in), .busy(busy), .done(done), .err_cnt(err_cnt), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cor_en) mem[cor_addr] <= cor_data;
    else if (w_en) mem[addr] <= data_in;
    if (r_en) rd_data <= mem[addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic corrupt(input logic [3:0] a, input logic [7:0] d);
    cor_en = 1'b1; cor_addr = a; cor_data = d;
    step();
    cor_en = 1'b0;
  endtask

  task automatic write_sweep(input logic [1:0] m, input logic [7:0] s, input logic [7:0] base,
                             input logic [7:0] inc, input logic both);
    int bad = 0;
    logic [7:0] e;
    mode = m; seed = s; wr_start = 1'b1; rd_start = both;
    for (int i = 0; i < 16; i++) begin
      step();
      wr_start = 1'b0; rd_start = (i == 5); mode = ~m; seed = ~s;
      e = base + inc * i[7:0];
      if (!w_en || !busy || done || addr != i[3:0] || data_in != e) bad++;
    end
    rd_start = 1'b0;
    check("wr_vectors", bad, 0);
    step();
    check("wr_done", int'(done), 1);
    check("wr_busy_end", int'(busy), 0);
    check("wr_wen_end", int'(w_en), 0);
    check("wr_addr_end", int'(addr), 0);
    check("wr_data_end", int'(data_in), 0);
    step();
    check("wr_done_pulse", int'(done), 0);
    check("wr_no_restart", int'(busy), 0);
    check("ram3", int'(mem[3]), int'(8'(base + inc * 8'd3)));
    check("ram15", int'(mem[15]), int'(8'(base + inc * 8'd15)));
  endtask

  task automatic read_sweep(input logic [1:0] m, input logic [7:0] s, input int abort_at,
                            input int exp_err, input int exp_flag);
    int n = 0, bad = 0, j;
    mode = m; seed = s; rd_start = 1'b1;
    step();
    rd_start = 1'b0; mode = ~m; seed = ~s;
    check("rd_busy", int'(busy), 1);
    check("rd_cnt_clr", int'(err_cnt), 0);
    check("rd_flag_clr", int'(err_flag), 0);
    check("rd_addr0", int'(addr), 0);
    for (j = 0; j < 200; j++) begin
      if (j == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_busy", int'(busy), 0);
        check("ab_ren", int'(r_en), 0);
        check("ab_addr", int'(addr), 0);
        check("ab_done", int'(done), 0);
        break;
      end
      if (r_en) begin
        if (j != 4 * (n + 1) || addr != n[3:0]) bad++;
        n++;
      end
      if (done) break;
      step();
    end
    if (abort_at < 0) begin
      check("rd_done_at", j, 66);
      check("rd_strobes", n, 16);
      check("rd_strobe_timing", bad, 0);
      check("rd_busy_end", int'(busy), 0);
    end
    check("rd_err_cnt", int'(err_cnt), exp_err);
    check("rd_err_flag", int'(err_flag), exp_flag);
    step();
    check("rd_done_pulse", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    #3 rst_n = 1'b0;
    #10;
    check("rst_wen", int'(w_en), 0);
    check("rst_ren", int'(r_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_errcnt", int'(err_cnt), 0);
    rst_n = 1'b1;
    step();
    mode = 2'd0; wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("mid_addr6", int'(addr), 6);
    #2 rst_n = 1'b0;
    #1;
    check("async_wen", int'(w_en), 0);
    check("async_addr", int'(addr), 0);
    check("async_busy", int'(busy), 0);
    check("async_data", int'(data_in), 0);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_errcnt", int'(err_cnt), 0);
    write_sweep(2'd0, 8'h00, 8'h00, 8'h01, 1'b0);
    read_sweep(2'd0, 8'h00, -1, 0, 0);
    corrupt(4'd5, 8'hAA);
    corrupt(4'd9, 8'h00);
    read_sweep(2'd0, 8'h00, -1, 2, 1);
    read_sweep(2'd1, 8'h00, -1, 16, 1);
    mode = 2'd0; wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("abw_addr7", int'(addr), 7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abw_wen", int'(w_en), 0);
    check("abw_addr", int'(addr), 0);
    check("abw_busy", int'(busy), 0);
    check("abw_done", int'(done), 0);
    check("abw_data", int'(data_in), 0);
    step();
    check("abw_no_done", int'(done), 0);
    write_sweep(2'd3, 8'hF8, 8'hF8, 8'h01, 1'b0);
    write_sweep(2'd1, 8'h33, 8'hFF, 8'hFF, 1'b1);
    read_sweep(2'd1, 8'h00, -1, 0, 0);
    corrupt(4'd0, 8'h00);
    read_sweep(2'd1, 8'h00, 5, 0, 0);
    read_sweep(2'd1, 8'h00, -1, 1, 1);
    read_sweep(2'd1, 8'h00, 10, 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
